uart_tx_out: RTL
================

# uart_tx_out

Serial UART transmitter (8N1, LSB first) that takes the CPU's output bytes and sends them to the host on the same link and baud setting the loader/receiver uses. It sits between the CPU data bus (write strobe plus byte) and the board TX pin. A small FIFO absorbs bursts of CPU writes while the serializer paces bits at `DELAY` clocks per bit.

## Interface
- `DELAY`, 234: clocks per bit period; legal range 2..65535.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, at least 2.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; clock `clk`.
- `wr_en` input 1: one-cycle write strobe; `wr_data` is pushed when `full`=0.
- `wr_data` input 8: byte to transmit.
- `tx` output 1: serial line, registered, idle high.
- `full` output 1: FIFO holds `FIFO_DEPTH` bytes.
- `busy` output 1: FSM not in IDLE, or FIFO not empty.
- `overflow` output 1: sticky; set when `wr_en`=1 while `full`=1.

## Operation
- FIFO:
  - Circular buffer with pointers of width `$clog2(FIFO_DEPTH)`, wrapping naturally.
  - Occupancy count is `$clog2(FIFO_DEPTH)+1` bits.
  - Push on `wr_en && !full`. Pop only on an FSM load event.
  - `full` and the empty condition are derived from the registered count.
- Write while full:
  - The byte is dropped and `overflow` is set.
  - This holds even if a pop happens on the same edge; `full` is not look-ahead.
- Push and pop on the same edge: the count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE -> START when the FIFO is non-empty. On this load event the head byte goes to the shift register, the FIFO pops, and `tx` is driven 0.
  - START -> DATA after `DELAY` cycles.
  - DATA shifts out 8 bits, LSB first, `DELAY` cycles each. A 3-bit index counts 0..7.
  - DATA -> STOP after bit 7 (or -> PARITY with the macro).
  - STOP: `tx`=1 for `DELAY` cycles.
  - At the end of STOP: if the FIFO is non-empty, reload directly into START with no idle gap; otherwise go to IDLE.
- Bit timer:
  - Width `$clog2(DELAY)`. Counts 0..`DELAY`-1 and clears at each bit boundary.
  - Held at 0 in IDLE.
- `tx` is a flop written at each state/bit boundary, so there are no glitches.
- Reset mid-frame:
  - `tx` goes to 1 after the reset edge and the FIFO is flushed.
  - The partial frame is abandoned, which the receiver sees as a framing error. This is accepted.

## Timing
- Reset values: `tx`=1, `full`=0, `busy`=0, `overflow`=0, state IDLE, count 0, timer 0.
- Latency: with the FSM in IDLE and the FIFO empty, a `wr_en` sampled at edge E gives `tx`=0 from edge E+1.
  - `busy`=1 from edge E (push) onward.
- Frame length: `10*DELAY` cycles (`11*DELAY` with parity).
  - Start-bit falling edge to the next start-bit falling edge, back-to-back, is exactly the frame length.
- `busy` falls at the edge where STOP completes with the FIFO empty.
- Throughput: one byte per frame. The CPU must poll `full`, or `busy` for a drain.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state between DATA and STOP. `tx` = XOR of the 8 data bits (even parity) for `DELAY` cycles.
  - Frame becomes 11 bits.
- Undefined: no PARITY state; 8N1 frame of 10 bits.
- Bit timer, FIFO and handshake are identical in both builds.

## Test plan
- Reset, then idle for 1000 cycles -> `tx`=1, `busy`=0, `full`=0, `overflow`=0 throughout.
- `DELAY`=4, write 0xA5 -> `tx` low from the next edge. Bits sampled mid-period read 0,1,0,1,0,0,1,0,1,1 (start, LSB..MSB, stop). `busy` clears 40 cycles after the start edge.
- `DELAY`=4, write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles (depth 4) -> 0x01 is popped immediately so all five are accepted. Five back-to-back frames of 40 cycles with no idle gap. `overflow`=0.
- `DELAY`=4, 6 consecutive writes -> `full`=1 after the 5th, 6th byte dropped, `overflow`=1 sticky until reset. The first five bytes are sent in order.
- Assert `reset` mid-DATA of 0xFF with 2 bytes queued -> `tx`=1 on the next cycle, `busy`=0, no further frames.
- With `UART_TX_PARITY_EN`, `DELAY`=4: send 0x07 -> parity bit 1, frame 44 cycles. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_out.sv
// uart_tx_out: UART transmitter (start, 8 data bits LSB first, stop) fed by a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (11-bit frame).
module uart_tx_out #(
    parameter int DELAY      = 234,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [7:0]       head_byte;

    // full is taken from the registered count, so a pop on the same edge never rescues a write
    assign full       = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = wr_en && !full;
    assign head_byte  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             load;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_end = (timer_q == TMR_LAST);
    assign pop     = load;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    timer_d   = '0;
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    // a queued byte starts its frame on this very edge: no idle gap
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d   = ST_START;
            timer_d   = '0;
            bit_idx_d = 3'd0;
            shift_d   = head_byte;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head_byte;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow = overflow_q;

endmodule
